alu_acc_seq: RTL and testbench
==============================

// Module: alu_acc_seq
// PURPOSE
//  Parametrised accumulator ALU for the datapath, replacing the one-hot-strobe accumulator.
//  Takes opcode-encoded operations through a valid/ready handshake.
//  Executes single-cycle ops in one clock, and MUL/DIV as W-cycle iterative (shift-add / restoring) ops.
//  Holds a W-bit accumulator ACC plus a W-bit extension register EXT (MUL high half / DIV remainder).
//  Flags are {DZ,ZF,CF,OF,SF}; the controller sequences ops via op_ready/done.
// PARAMETERS
//  W    16              datapath width (>=4, power of two)
//  SHW  $clog2(W)       shift-amount width, taken from operand[SHW-1:0]
// PORTS
//  clk       in   1    clock, all state updates on rising edge
//  rst       in   1    synchronous reset, active-high
//  op_valid  in   1    op/operand valid this cycle
//  op_ready  out  1    1 = idle, can accept an op
//  op        in   4    opcode (encoding below)
//  operand   in   W    second operand (BR value)
//  acc_out   out  W    ACC register
//  ext_out   out  W    EXT register
//  flags     out  5    {DZ,ZF,CF,OF,SF}, registered
//  done      out  1    one-cycle pulse: result/flags of accepted op are valid
// BEHAVIOUR
//  Reset (rst=1 at edge): ACC=0, EXT=0, flags=0, done=0, state=IDLE, op_ready=1.
//   Reset during MUL/DIV aborts the op, with no done pulse.
//  Accept = op_valid & op_ready at an edge. op_valid while busy is ignored (not queued).
//  Opcodes: 0 NOP, 1 CLR, 2 LOAD, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 SHL, 8 SHR (logical),
//   9 SAR (arith), A AND, B OR, C XOR, D NOT(ACC), E/F reserved = NOP.
//  Single-cycle ops, accepted at edge k: ACC/EXT/flags updated at edge k; done=1 for the cycle after edge k.
//   op_ready stays 1, so back-to-back accepts are allowed.
//  FSM: IDLE -> MUL or DIV on accept. Both run exactly W iterations, one per edge, then return to IDLE.
//   Final ACC/EXT/flags and done are at edge k+W. op_ready=0 from edge k until edge k+W; op_ready=1 again after edge k+W.
//  ADD: {CF,ACC}=ACC+operand (W+1 bit). OF = signed overflow.
//  SUB: ACC=ACC-operand. CF = borrow (ACC<operand unsigned). OF = signed overflow.
//  MUL: unsigned, 2W-bit product P. ACC=P[W-1:0], EXT=P[2W-1:W]. CF=OF=(EXT!=0).
//  DIV: unsigned restoring. ACC=quotient, EXT=remainder. CF=OF=0.
//   If operand==0: single-cycle, ACC/EXT unchanged, DZ=1, other flags 0, done at edge k.
//  SHL/SHR/SAR by n=operand[SHW-1:0]: CF = last bit shifted out; n=0 -> ACC unchanged, CF=0. OF=0.
//  LOAD: ACC=operand. CLR: ACC=0, EXT=0.
//  LOAD/CLR/logic ops: CF=OF=0.
//  ZF = (new ACC==0). SF = new ACC[W-1].
//  DZ is cleared by any completing op except DIV-by-zero.
//  NOP/reserved: ACC/EXT/flags held, done still pulses.
//  Operand is sampled at accept. Changes on operand during MUL/DIV have no effect.
//  EXT is written only by MUL, DIV and CLR.
// TESTING (W=16)
//  LOAD 0x7FFF; ADD 0x0001 -> ACC=0x8000, flags=0b00011 (OF,SF), done 1 cycle after accept.
//  CLR; SUB 0x0001 -> ACC=0xFFFF, CF=1, SF=1, OF=0, ZF=0.
//  LOAD 0x0123; MUL 0x0100 -> ACC=0x2300, EXT=0x0001, CF=OF=1.
//   done exactly 16 cycles after accept; op_ready=0 throughout; op_valid pulses mid-op ignored.
//  LOAD 100; DIV 7 -> ACC=14, EXT=2, ZF=0, 16 cycles. Then DIV 0 -> ACC=14 unchanged, DZ=1, done after 1 cycle.
//  LOAD 0x8001; SHL 1 -> ACC=0x0002, CF=1. SAR 0x8000 by 15 -> 0xFFFF, SF=1. SHR n=0 -> ACC unchanged, CF=0.
//  Start MUL, assert rst 5 cycles in -> next cycle ACC=0, EXT=0, flags=0, op_ready=1, and no done pulse.

Source files
------------

// File: rtl/alu_acc_seq.sv
// Accumulator ALU: ACC/EXT registers and flags, with single-cycle ops plus iterative MUL/DIV.
// Latency: single-cycle ops finish at the accept edge. MUL and non-zero DIV finish W edges after accept.
// Backpressure: op_ready drops while MUL/DIV iterate. op_valid seen while busy is dropped, not queued.
//
// Ports:
//   clk, rst        rising-edge clock; synchronous active-high reset
//   op_valid/ready  operation handshake; accept = op_valid & op_ready at a rising edge
//   op, operand     4-bit opcode and W-bit second operand, both sampled at accept
//   acc_out/ext_out ACC register and EXT register (EXT holds MUL high half or DIV remainder)
//   flags           {DZ,ZF,CF,OF,SF}, registered
//   done            one-cycle pulse once the result and flags of an accepted op are visible
module alu_acc_seq #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] operand,
  output logic [W-1:0] acc_out,
  output logic [W-1:0] ext_out,
  output logic [4:0]   flags,
  output logic         done
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CLR  = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_DIV  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_SAR  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_OR   = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  typedef struct packed {
    logic dz;
    logic zf;
    logic cf;
    logic of;
    logic sf;
  } flags_t;

  // Architectural state
  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   ext_q, ext_d;
  flags_t         flg_q, flg_d;
  logic           done_q, done_d;
  logic           rdy_q, rdy_d;

  // Iteration state for MUL/DIV.
  // MUL: hi = partial product high half, lo = multiplier shifting out / product low half.
  // DIV: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  function automatic flags_t mk_flags(input logic [W-1:0] a, input logic cf, input logic of);
    flags_t f;
    f.dz = 1'b0;
    f.zf = (a == '0);
    f.cf = cf;
    f.of = of;
    f.sf = a[W-1];
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the current ACC and the live operand.
  // ---------------------------------------------------------------------------
  logic [SHW-1:0] sh_n;
  logic [W:0]     sum_w;
  logic [W:0]     dif_w;
  logic [W:0]     shl_w;
  logic [W:0]     shr_w;
  logic [W:0]     sar_w;

  assign sh_n  = operand[SHW-1:0];
  assign sum_w = {1'b0, acc_q} + {1'b0, operand};
  // Top bit of the widened difference is the unsigned borrow.
  assign dif_w = {1'b0, acc_q} - {1'b0, operand};
  // An extra guard bit on the far side of each shift catches the last bit
  // shifted out. For n=0 it stays 0.
  assign shl_w = {1'b0, acc_q} << sh_n;
  assign shr_w = {acc_q, 1'b0} >> sh_n;
  assign sar_w = $signed({acc_q, 1'b0}) >>> sh_n;

  logic [W-1:0] sc_acc;
  logic         sc_cf;
  logic         sc_of;

  always_comb begin
    sc_acc = acc_q;
    sc_cf  = 1'b0;
    sc_of  = 1'b0;
    case (op)
      OP_CLR:  sc_acc = '0;
      OP_LOAD: sc_acc = operand;
      OP_ADD: begin
        sc_acc = sum_w[W-1:0];
        sc_cf  = sum_w[W];
        sc_of  = (acc_q[W-1] == operand[W-1]) && (sum_w[W-1] != acc_q[W-1]);
      end
      OP_SUB: begin
        sc_acc = dif_w[W-1:0];
        sc_cf  = dif_w[W];
        sc_of  = (acc_q[W-1] != operand[W-1]) && (dif_w[W-1] != acc_q[W-1]);
      end
      OP_SHL: begin
        sc_acc = shl_w[W-1:0];
        sc_cf  = shl_w[W];
      end
      OP_SHR: begin
        sc_acc = shr_w[W:1];
        sc_cf  = shr_w[0];
      end
      OP_SAR: begin
        sc_acc = sar_w[W:1];
        sc_cf  = sar_w[0];
      end
      OP_AND:  sc_acc = acc_q & operand;
      OP_OR:   sc_acc = acc_q | operand;
      OP_XOR:  sc_acc = acc_q ^ operand;
      OP_NOT:  sc_acc = ~acc_q;
      default: sc_acc = acc_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One MUL step (shift-add) and one DIV step (restoring) on the iteration regs.
  // ---------------------------------------------------------------------------
  logic [W:0]   mul_add;
  logic [W-1:0] mul_hi_nx;
  logic [W-1:0] mul_lo_nx;
  logic [W:0]   div_sh;
  logic         div_ge;
  logic [W-1:0] div_sub;
  logic [W-1:0] div_hi_nx;
  logic [W-1:0] div_lo_nx;

  assign mul_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_nx = mul_add[W:1];
  assign mul_lo_nx = {mul_add[0], lo_q[W-1:1]};

  assign div_sh    = {hi_q, lo_q[W-1]};
  assign div_ge    = (div_sh >= {1'b0, opnd_q});
  // When div_ge holds, the difference is below the divisor, so W bits hold it exactly.
  assign div_sub   = div_sh[W-1:0] - opnd_q;
  assign div_hi_nx = div_ge ? div_sub : div_sh[W-1:0];
  assign div_lo_nx = {lo_q[W-2:0], div_ge};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic accept;
  assign accept = op_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    rdy_d   = rdy_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MUL: begin
              state_d = S_MUL;
              rdy_d   = 1'b0;
              opnd_d  = operand;
              hi_d    = '0;
              lo_d    = acc_q;
              cnt_d   = SHW'(W - 1);
            end
            OP_DIV: begin
              if (operand == '0) begin
                // Divide by zero completes at once and leaves ACC/EXT alone.
                flg_d    = '0;
                flg_d.dz = 1'b1;
                done_d   = 1'b1;
              end else begin
                state_d = S_DIV;
                rdy_d   = 1'b0;
                opnd_d  = operand;
                hi_d    = '0;
                lo_d    = acc_q;
                cnt_d   = SHW'(W - 1);
              end
            end
            OP_CLR, OP_LOAD, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_SAR,
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              acc_d  = sc_acc;
              if (op == OP_CLR) begin
                ext_d = '0;
              end
              flg_d  = mk_flags(sc_acc, sc_cf, sc_of);
              done_d = 1'b1;
            end
            default: begin
              // NOP and reserved codes: state held, completion still signalled.
              done_d = 1'b1;
            end
          endcase
        end
      end

      S_MUL: begin
        hi_d  = mul_hi_nx;
        lo_d  = mul_lo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          acc_d   = mul_lo_nx;
          ext_d   = mul_hi_nx;
          flg_d   = mk_flags(mul_lo_nx, mul_hi_nx != '0, mul_hi_nx != '0);
          done_d  = 1'b1;
        end
      end

      S_DIV: begin
        hi_d  = div_hi_nx;
        lo_d  = div_lo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          acc_d   = div_lo_nx;
          ext_d   = div_hi_nx;
          flg_d   = mk_flags(div_lo_nx, 1'b0, 1'b0);
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset abandons any MUL/DIV in flight without a done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ext_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ext_q   <= ext_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ready = rdy_q;
  assign acc_out  = acc_q;
  assign ext_out  = ext_q;
  assign flags    = flg_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Testbench for alu_acc_seq at W=16: a directed vector table, then random ops scored against a behavioural model.
// A monitor pops the expected result for each done pulse and reports any done pulse that has no matching op.
// Hand-written sequences cover reset state, ignored mid-op requests, and reset abort during MUL.
module tb_alu_acc_seq;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_s;
  logic [W-1:0]  operand;
  logic [W-1:0]  acc_out;
  logic [W-1:0]  ext_out;
  logic [4:0]    flags;
  logic          done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] opnd;
    logic [15:0] acc;
    logic [15:0] ext;
    logic [4:0]  flg;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic [15:0] ext;
    logic [4:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[30];

  logic [15:0] m_acc;
  logic [15:0] m_ext;
  logic [4:0]  m_flg;

  alu_acc_seq #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op_s),
    .operand  (operand),
    .acc_out  (acc_out),
    .ext_out  (ext_out),
    .flags    (flags),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with no op outstanding (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("acc", acc_out, mon_e.acc);
        chk("ext", ext_out, mon_e.ext);
        chk("flags", flags, mon_e.flg);
      end
    end
  end

  // Behavioural reference: arithmetic operators and bit-at-a-time shifts.
  task automatic model_step(input logic [3:0] o, input logic [15:0] d);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] t;
    int ai, bi, ri, n;
    logic cf, of;
    cf = 1'b0;
    of = 1'b0;
    ai = $signed(m_acc);
    bi = $signed(d);
    case (o)
      4'h1: begin m_acc = 16'h0; m_ext = 16'h0; end
      4'h2: m_acc = d;
      4'h3: begin
        s = {1'b0, m_acc} + {1'b0, d};
        ri = ai + bi;
        cf = s[16];
        of = (ri > 32767) || (ri < -32768);
        m_acc = s[15:0];
      end
      4'h4: begin
        ri = ai - bi;
        cf = (m_acc < d);
        of = (ri > 32767) || (ri < -32768);
        m_acc = m_acc - d;
      end
      4'h5: begin
        p = {16'h0, m_acc} * {16'h0, d};
        m_acc = p[15:0];
        m_ext = p[31:16];
        cf = (m_ext != 16'h0);
        of = cf;
      end
      4'h6: begin
        if (d == 16'h0) begin
          m_flg = 5'b10000;
          return;
        end
        t = m_acc;
        m_acc = t / d;
        m_ext = t % d;
      end
      4'h7, 4'h8, 4'h9: begin
        n = int'(d[3:0]);
        for (int i = 0; i < n; i++) begin
          if (o == 4'h7) begin
            cf = m_acc[15];
            m_acc = {m_acc[14:0], 1'b0};
          end else begin
            cf = m_acc[0];
            m_acc = {(o == 4'h9) ? m_acc[15] : 1'b0, m_acc[15:1]};
          end
        end
      end
      4'hA: m_acc = m_acc & d;
      4'hB: m_acc = m_acc | d;
      4'hC: m_acc = m_acc ^ d;
      4'hD: m_acc = ~m_acc;
      default: return;
    endcase
    m_flg = {1'b0, m_acc == 16'h0, cf, of, m_acc[15]};
  endtask

  // Issue one op, push its expectation, and check handshake and latency.
  // While MUL/DIV is busy, LOAD requests are pulsed and must be ignored.
  task automatic do_op(input logic [3:0] o, input logic [15:0] d, input exp_t e);
    int lat;
    int exp_lat;
    exp_lat = (o == 4'h5 || (o == 4'h6 && d != 16'h0)) ? W : 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_s     = o;
    operand  = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    operand  = 16'($urandom);
    chk("ready_after_accept", op_ready, exp_lat == 0);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      chk("busy_ready", op_ready, 0);
      @(negedge clk);
      if (lat % 4 == 2 || lat == W - 1) begin
        op_valid = 1'b1;
        op_s     = 4'h2;
        operand  = 16'($urandom);
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("ready_after_done", op_ready, 1);
  endtask

  task automatic do_model_op(input logic [3:0] o, input logic [15:0] d);
    exp_t e;
    model_step(o, d);
    e.acc = m_acc;
    e.ext = m_ext;
    e.flg = m_flg;
    do_op(o, d, e);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [15:0] rd;
    exp_t        ve;

    //         op     operand   acc       ext       {DZ,ZF,CF,OF,SF}
    vecs[0]  = '{4'h2, 16'h7FFF, 16'h7FFF, 16'h0000, 5'b00000};
    vecs[1]  = '{4'h3, 16'h0001, 16'h8000, 16'h0000, 5'b00011};
    vecs[2]  = '{4'h1, 16'h0000, 16'h0000, 16'h0000, 5'b01000};
    vecs[3]  = '{4'h4, 16'h0001, 16'hFFFF, 16'h0000, 5'b00101};
    vecs[4]  = '{4'h2, 16'h0123, 16'h0123, 16'h0000, 5'b00000};
    vecs[5]  = '{4'h5, 16'h0100, 16'h2300, 16'h0001, 5'b00110};
    vecs[6]  = '{4'h2, 16'd100,  16'd100,  16'h0001, 5'b00000};
    vecs[7]  = '{4'h6, 16'd7,    16'd14,   16'd2,    5'b00000};
    vecs[8]  = '{4'h6, 16'h0000, 16'd14,   16'd2,    5'b10000};
    vecs[9]  = '{4'h2, 16'h8001, 16'h8001, 16'd2,    5'b00001};
    vecs[10] = '{4'h7, 16'h0001, 16'h0002, 16'd2,    5'b00100};
    vecs[11] = '{4'h2, 16'h8000, 16'h8000, 16'd2,    5'b00001};
    vecs[12] = '{4'h9, 16'h000F, 16'hFFFF, 16'd2,    5'b00001};
    vecs[13] = '{4'h8, 16'h0010, 16'hFFFF, 16'd2,    5'b00001};
    vecs[14] = '{4'h8, 16'h0004, 16'h0FFF, 16'd2,    5'b00100};
    vecs[15] = '{4'hA, 16'h00F0, 16'h00F0, 16'd2,    5'b00000};
    vecs[16] = '{4'hB, 16'h0F00, 16'h0FF0, 16'd2,    5'b00000};
    vecs[17] = '{4'hC, 16'h0FFF, 16'h000F, 16'd2,    5'b00000};
    vecs[18] = '{4'hD, 16'h1234, 16'hFFF0, 16'd2,    5'b00001};
    vecs[19] = '{4'h0, 16'h5555, 16'hFFF0, 16'd2,    5'b00001};
    vecs[20] = '{4'hE, 16'h0000, 16'hFFF0, 16'd2,    5'b00001};
    vecs[21] = '{4'h3, 16'h0010, 16'h0000, 16'd2,    5'b01100};
    vecs[22] = '{4'h2, 16'hFFFF, 16'hFFFF, 16'd2,    5'b00001};
    vecs[23] = '{4'h5, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00110};
    vecs[24] = '{4'h6, 16'h0003, 16'h0000, 16'h0001, 5'b01000};
    vecs[25] = '{4'h4, 16'h8000, 16'h8000, 16'h0001, 5'b00111};
    vecs[26] = '{4'h6, 16'h0000, 16'h8000, 16'h0001, 5'b10000};
    vecs[27] = '{4'h1, 16'h0000, 16'h0000, 16'h0000, 5'b01000};
    vecs[28] = '{4'h2, 16'h4000, 16'h4000, 16'h0000, 5'b00000};
    vecs[29] = '{4'h9, 16'h000F, 16'h0000, 16'h0000, 5'b01100};

    rst      = 1'b1;
    op_valid = 1'b0;
    op_s     = 4'h0;
    operand  = 16'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", acc_out, 16'h0);
    chk("rst_ext", ext_out, 16'h0);
    chk("rst_flags", flags, 5'b0);
    chk("rst_ready", op_ready, 1);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table. Single-cycle rows issue back to back.
    for (int i = 0; i < 30; i++) begin
      ve.acc = vecs[i].acc;
      ve.ext = vecs[i].ext;
      ve.flg = vecs[i].flg;
      do_op(vecs[i].op, vecs[i].opnd, ve);
    end
    m_acc = vecs[29].acc;
    m_ext = vecs[29].ext;
    m_flg = vecs[29].flg;

    // Reset five cycles into a MUL: abort with no done pulse.
    do_model_op(4'h2, 16'h0123);
    @(negedge clk);
    op_valid = 1'b1;
    op_s     = 4'h5;
    operand  = 16'h0100;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("abort_busy", op_ready, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_acc", acc_out, 16'h0);
    chk("abort_ext", ext_out, 16'h0);
    chk("abort_flags", flags, 5'b0);
    chk("abort_ready", op_ready, 1);
    chk("abort_done", done, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    m_acc = 16'h0;
    m_ext = 16'h0;
    m_flg = 5'b0;

    // Random ops scored against the model
    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      rd = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rd = 16'h0;
      do_model_op(ro, rd);
    end

    // done is a single-cycle pulse, and nothing is left outstanding
    @(posedge clk);
    #1;
    chk("done_pulse_end", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
